// File: rtl/param_register_file.sv
// Parametrised register file: two registered read ports with write-first
// bypass, one write port, optional hardwired zero register and a sequenced
// bulk-clear engine that walks every register to zero, one per cycle.
module param_register_file #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter bit          ZERO_REG = 1'b0,
   parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] writeRegister,
   input  logic [WIDTH-1:0]  writeData,
   input  logic [ADDR_W-1:0] readRegister1,
   input  logic [ADDR_W-1:0] readRegister2,
   input  logic              immediate,
   input  logic [WIDTH-1:0]  ltValue,
   input  logic              clearStart,
   output logic [WIDTH-1:0]  readData1,
   output logic [WIDTH-1:0]  readData2,
   output logic              busy
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [WIDTH-1:0]  rd1_d, rd2_d;
   logic              clearing;
   logic              write_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DepthW;
   endfunction

   // Value a read sees after this edge's update: clear and accepted write forward.
   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] v;
      v = '0;
      if (!in_range(a)) begin
         v = '0;
      end else if (ZERO_REG && (a == '0)) begin
         v = '0;
      end else if (clearing && (a == index_q)) begin
         v = '0;
      end else if (write_ok && (a == writeRegister)) begin
         v = writeData;
      end else begin
         v = regs_q[a];
      end
      return v;
   endfunction

   assign clearing = (state_q == StClear);
   assign busy     = clearing;

   // Writes are dropped while clearing, out of range, or aimed at a hardwired r0.
   assign write_ok = regWrite && !clearing && in_range(writeRegister) &&
                     !(ZERO_REG && (writeRegister == '0));

   // Clear engine next state; clearStart is ignored once a clear is running.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      unique case (state_q)
         StIdle: begin
            if (clearStart) begin
               state_d = StClear;
               index_d = '0;
            end
         end
         StClear: begin
            if (index_q == LastIdx) begin
               state_d = StIdle;
               index_d = '0;
            end else begin
               index_d = index_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            index_d = '0;
         end
      endcase
   end

   // Read-port next values; immediate overrides port 2 without range check.
   always_comb begin
      rd1_d = read_port(readRegister1);
      rd2_d = immediate ? ltValue : read_port(readRegister2);
   end

   // Clear engine state register.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   // Register array: clear slot takes priority (writes are dropped then anyway).
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (clearing && (index_q == ADDR_W'(i))) begin
               regs_q[i] <= '0;
            end else if (write_ok && (writeRegister == ADDR_W'(i))) begin
               regs_q[i] <= writeData;
            end
         end
      end
   end

   // Registered read data.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         readData1 <= '0;
         readData2 <= '0;
      end else begin
         readData1 <= rd1_d;
         readData2 <= rd2_d;
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: four register-file configurations share one stimulus
// stream and are compared every cycle against an array/counter reference model,
// plus directed constant checks on the 8x8 and zero-register instances.
module tb_param_register_file;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetN, regWrite, immediate, clearStart;
   logic [3:0]  wa, ra1, ra2;
   logic [15:0] wd, lt;

   logic [7:0]  rd1_a, rd2_a, rd1_z, rd2_z;
   logic [15:0] rd1_b, rd2_b;
   logic [3:0]  rd1_c, rd2_c;
   logic        busy_a, busy_z, busy_b, busy_c;

   int compared   = 0;
   int mismatched = 0;

   // Instance 0: 8x8, instance 1: 8x6 zero reg, instance 2: 16x16, instance 3: 4x5.
   param_register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) u_a (
      .clock(clock), .resetN(resetN), .regWrite(regWrite), .writeRegister(wa[2:0]),
      .writeData(wd[7:0]), .readRegister1(ra1[2:0]), .readRegister2(ra2[2:0]),
      .immediate(immediate), .ltValue(lt[7:0]), .clearStart(clearStart),
      .readData1(rd1_a), .readData2(rd2_a), .busy(busy_a));

   param_register_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) u_z (
      .clock(clock), .resetN(resetN), .regWrite(regWrite), .writeRegister(wa[2:0]),
      .writeData(wd[7:0]), .readRegister1(ra1[2:0]), .readRegister2(ra2[2:0]),
      .immediate(immediate), .ltValue(lt[7:0]), .clearStart(clearStart),
      .readData1(rd1_z), .readData2(rd2_z), .busy(busy_z));

   param_register_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0)) u_b (
      .clock(clock), .resetN(resetN), .regWrite(regWrite), .writeRegister(wa),
      .writeData(wd), .readRegister1(ra1), .readRegister2(ra2),
      .immediate(immediate), .ltValue(lt), .clearStart(clearStart),
      .readData1(rd1_b), .readData2(rd2_b), .busy(busy_b));

   param_register_file #(.WIDTH(4), .DEPTH(5), .ZERO_REG(1'b0)) u_c (
      .clock(clock), .resetN(resetN), .regWrite(regWrite), .writeRegister(wa[2:0]),
      .writeData(wd[3:0]), .readRegister1(ra1[2:0]), .readRegister2(ra2[2:0]),
      .immediate(immediate), .ltValue(lt[3:0]), .clearStart(clearStart),
      .readData1(rd1_c), .readData2(rd2_c), .busy(busy_c));

   // Reference model.
   int unsigned cfg_w  [4] = '{8, 8, 16, 4};
   int unsigned cfg_d  [4] = '{8, 6, 16, 5};
   int unsigned cfg_aw [4] = '{3, 3, 4, 3};
   bit          cfg_z  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   logic [15:0] mem [4][16];
   int unsigned clr_left [4];  // clear edges still to come; 0 means idle
   logic [15:0] e_rd1 [4];
   logic [15:0] e_rd2 [4];
   logic        e_busy [4];

   function automatic logic [15:0] msk(input int k, input logic [15:0] v);
      return v & 16'((32'h1 << cfg_w[k]) - 32'h1);
   endfunction

   function automatic int unsigned adr(input int k, input logic [3:0] a);
      return 32'(a) & ((32'h1 << cfg_aw[k]) - 32'h1);
   endfunction

   function automatic logic [15:0] mrd(input int k, input int unsigned a);
      if (a >= cfg_d[k]) return 16'h0;
      if (cfg_z[k] && a == 0) return 16'h0;
      return mem[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < 16; r++) mem[k][r] = 16'h0;
         clr_left[k] = 0;
         e_rd1[k]    = 16'h0;
         e_rd2[k]    = 16'h0;
         e_busy[k]   = 1'b0;
      end
   endtask

   // One rising edge: updates happen first, then reads see the new contents.
   task automatic model_edge();
      int unsigned a;
      for (int k = 0; k < 4; k++) begin
         if (clr_left[k] > 0) begin
            mem[k][cfg_d[k] - clr_left[k]] = 16'h0;
            clr_left[k] = clr_left[k] - 1;
         end else begin
            a = adr(k, wa);
            if (regWrite && a < cfg_d[k] && !(cfg_z[k] && a == 0)) mem[k][a] = msk(k, wd);
            if (clearStart) clr_left[k] = cfg_d[k];
         end
         e_rd1[k]  = mrd(k, adr(k, ra1));
         e_rd2[k]  = immediate ? msk(k, lt) : mrd(k, adr(k, ra2));
         e_busy[k] = (clr_left[k] > 0);
      end
   endtask

   function automatic logic [15:0] obs1(input int k);
      case (k)
         0:       return {8'h0, rd1_a};
         1:       return {8'h0, rd1_z};
         2:       return rd1_b;
         default: return {12'h0, rd1_c};
      endcase
   endfunction

   function automatic logic [15:0] obs2(input int k);
      case (k)
         0:       return {8'h0, rd2_a};
         1:       return {8'h0, rd2_z};
         2:       return rd2_b;
         default: return {12'h0, rd2_c};
      endcase
   endfunction

   function automatic logic obsb(input int k);
      case (k)
         0:       return busy_a;
         1:       return busy_z;
         2:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rd1[%0d]", k), obs1(k), e_rd1[k]);
         chk($sformatf("rd2[%0d]", k), obs2(k), e_rd2[k]);
         chk($sformatf("busy[%0d]", k), {15'h0, obsb(k)}, {15'h0, e_busy[k]});
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic cyc(input logic we, input logic [3:0] a, input logic [15:0] d,
                      input logic [3:0] r1, input logic [3:0] r2, input logic im,
                      input logic [15:0] l, input logic cs);
      regWrite = we; wa = a; wd = d; ra1 = r1; ra2 = r2;
      immediate = im; lt = l; clearStart = cs;
      tick();
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next edge.
   task automatic mid_reset(input string tag);
      @(posedge clock);
      #2 resetN = 1'b0;
      model_reset();
      #1;
      chk({tag, "_rd1"}, {8'h0, rd1_a}, 16'h0);
      chk({tag, "_rd2"}, {8'h0, rd2_a}, 16'h0);
      chk({tag, "_busy"}, {15'h0, busy_a}, 16'h0);
      check_all();
      @(negedge clock);
      resetN = 1'b1;
   endtask

   initial begin
      resetN = 1'b1; regWrite = 1'b0; immediate = 1'b0; clearStart = 1'b0;
      wa = '0; ra1 = '0; ra2 = '0; wd = '0; lt = '0;
      model_reset();
      #2 resetN = 1'b0;
      #1;
      chk("por_rd1", {8'h0, rd1_a}, 16'h0);
      chk("por_busy", {15'h0, busy_a}, 16'h0);
      check_all();
      @(negedge clock);
      resetN = 1'b1;

      // Write-first bypass on both ports, then immediate on port 2.
      cyc(1'b1, 4'd3, 16'h00A5, 4'd3, 4'd3, 1'b0, 16'h0, 1'b0);
      chk("byp_rd1", {8'h0, rd1_a}, 16'h00A5);
      chk("byp_rd2", {8'h0, rd2_a}, 16'h00A5);
      cyc(1'b0, 4'd0, 16'h0, 4'd3, 4'd3, 1'b1, 16'h003C, 1'b0);
      chk("imm_rd2", {8'h0, rd2_a}, 16'h003C);
      chk("imm_rd1", {8'h0, rd1_a}, 16'h00A5);

      // Reset with loaded registers, then read every address back.
      mid_reset("rst");
      for (int r = 0; r < 16; r++) begin
         cyc(1'b0, 4'd0, 16'h0, 4'(r), 4'(15 - r), 1'b0, 16'h0, 1'b0);
         if (r == 3) chk("rst_r3", {8'h0, rd1_a}, 16'h0);
      end

      // Hardwired zero register and out-of-range write on the 6-deep instance.
      cyc(1'b1, 4'd0, 16'h00FF, 4'd0, 4'd0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 4'd7, 16'h00FF, 4'd0, 4'd7, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 4'd0, 16'h0, 4'd0, 4'd7, 1'b0, 16'h0, 1'b0);
      chk("zr_r0", {8'h0, rd1_z}, 16'h0);
      chk("zr_a7", {8'h0, rd2_z}, 16'h0);
      cyc(1'b1, 4'd5, 16'h0011, 4'd5, 4'd5, 1'b0, 16'h0, 1'b0);
      chk("zr_r5", {8'h0, rd1_z}, 16'h0011);

      // Bulk clear: fill 1..8, watch r5 fall at E+6, busy for exactly 8 cycles.
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i), 16'(i + 1), 4'd0, 4'd0, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 1'b0, 16'h0, 1'b1);
      chk("clr_r5_e0", {8'h0, rd1_a}, 16'h6);
      chk("clr_busy_e0", {15'h0, busy_a}, 16'h1);
      for (int i = 1; i <= 8; i++) begin
         cyc(i == 3, 4'd1, 16'h0099, 4'd5, 4'd1, 1'b0, 16'h0, 1'b0);
         chk($sformatf("clr_r5_e%0d", i), {8'h0, rd1_a}, (i < 6) ? 16'h6 : 16'h0);
         chk($sformatf("clr_busy_e%0d", i), {15'h0, busy_a}, (i < 8) ? 16'h1 : 16'h0);
      end
      cyc(1'b0, 4'd0, 16'h0, 4'd1, 4'd7, 1'b0, 16'h0, 1'b0);
      chk("clr_drop_r1", {8'h0, rd1_a}, 16'h0);
      chk("clr_r7", {8'h0, rd2_a}, 16'h0);

      // Same-cycle write with clearStart, and a second clearStart while busy.
      cyc(1'b1, 4'd2, 16'h0077, 4'd2, 4'd2, 1'b0, 16'h0, 1'b1);
      chk("cs_wr_r2", {8'h0, rd1_a}, 16'h0077);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0, 16'h0, i == 3);
         chk($sformatf("cs2_busy_e%0d", i), {15'h0, busy_a}, (i < 8) ? 16'h1 : 16'h0);
      end
      cyc(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0, 16'h0, 1'b0);
      chk("cs_clr_r2", {8'h0, rd1_a}, 16'h0);

      // Reset at clear index 4; afterwards the engine must accept a new start.
      for (int r = 0; r < 16; r++) cyc(1'b1, 4'(r), 16'hBEEF, 4'd0, 4'd0, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 16'h0, 1'b1);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 4'd0, 16'h0, 4'd6, 4'd0, 1'b0, 16'h0, 1'b0);
      mid_reset("rst_clr");
      cyc(1'b0, 4'd0, 16'h0, 4'd6, 4'd7, 1'b0, 16'h0, 1'b1);
      chk("rst_clr_r6", {8'h0, rd1_a}, 16'h0);
      chk("rst_clr_restart", {15'h0, busy_a}, 16'h1);
      for (int i = 0; i < 16; i++) cyc(1'b0, 4'd0, 16'h0, 4'(i), 4'd0, 1'b0, 16'h0, 1'b0);

      // Random stream across all four configurations.
      for (int n = 0; n < 600; n++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom()),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) == 0, 16'($urandom()), $urandom_range(0, 39) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
